// File: rtl/hn_rx_link.sv
// hn_rx_link: receive side of an HN link. Three channels (REQ, RSP, DAT) each
// have an L-credit issuer and a small FIFO of {srcID, opcode}. A single
// registered output stage presents one flit at a time to the HN controller.
// Build option: define HN_RX_RR_ARB_EN to get round-robin arbitration
// (REQ->RSP->DAT). Without it, arbitration is fixed priority RSP > DAT > REQ.
module hn_rx_link #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [127:0] RX_REQFLIT_128,
  input  logic [127:0] RX_RSPFLIT_128,
  input  logic [127:0] RX_DATFLIT_128,
  input  logic         RX_REQFLITV,
  input  logic         RX_RSPFLITV,
  input  logic         RX_DATFLITV,
  input  logic         RX_REQFLITPEND,
  input  logic         RX_RSPFLITPEND,
  input  logic         RX_DATFLITPEND,
  output logic         RX_REQLCRDV,
  output logic         RX_RSPLCRDV,
  output logic         RX_DATLCRDV,
  output logic [6:0]   rx_opcode,
  output logic [6:0]   rx_srcID,
  output logic [1:0]   rx_chan,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic         proto_err
);

  // Channel index 0 = REQ, 1 = RSP, 2 = DAT; rx_chan encodes index + 1.
  localparam int          PW       = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [1:0]  DEPTH_M1 = 2'(FIFO_DEPTH - 1);

  typedef enum logic {CR_INIT, CR_RUN} cr_state_e;

  // Only opcode and srcID are kept; PEND and the upper flit bits are dropped.
  logic        unused_bits;
  assign unused_bits = ^{RX_REQFLIT_128[127:14], RX_RSPFLIT_128[127:14],
                         RX_DATFLIT_128[127:14], RX_REQFLITPEND,
                         RX_RSPFLITPEND, RX_DATFLITPEND};

  logic [13:0] flit_in [3];
  logic [2:0]  flitv;
  assign flit_in[0] = RX_REQFLIT_128[13:0];
  assign flit_in[1] = RX_RSPFLIT_128[13:0];
  assign flit_in[2] = RX_DATFLIT_128[13:0];
  assign flitv      = {RX_DATFLITV, RX_RSPFLITV, RX_REQFLITV};

  // Per-channel FIFO storage and bookkeeping
  logic [13:0]   mem_q    [3][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [3];
  logic [PW-1:0] rd_ptr_q [3];
  logic [1:0]    fcnt_q   [3];

  // Per-channel credit state
  cr_state_e  cr_state_q [3], cr_state_d [3];
  logic [1:0] init_cnt_q [3], init_cnt_d [3];
  logic [1:0] cred_q     [3], cred_d     [3];
  logic [1:0] pend_q     [3], pend_d     [3];
  logic [2:0] lcrdv_q, lcrdv_d;
  logic       proto_err_q, proto_err_d;

  // Output stage
  logic       rx_valid_q, rx_valid_d;
  logic [1:0] rx_chan_q, rx_chan_d;
  logic [6:0] rx_op_q, rx_op_d;
  logic [6:0] rx_src_q, rx_src_d;

  // Control
  logic        accept, load;
  logic [2:0]  push_ok, fifo_empty, cand_v, grant, take, fifo_wr, fifo_rd, ret;
  logic [13:0] cand_data [3];
  logic [13:0] sel_data;
  logic [1:0]  grant_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Candidate per channel: FIFO head, or the arriving flit when the FIFO is empty
  // NOTE: every always_comb output gets a value on every path (defaults first) so no latch is inferred.
  always_comb begin
    accept = rx_valid_q && rx_ready;
    load   = !rx_valid_q || rx_ready;
    push_ok    = '0;
    fifo_empty = '0;
    cand_v     = '0;
    ret        = '0;
    for (int c = 0; c < 3; c++) begin
      push_ok[c]    = flitv[c] && (cred_q[c] != 2'd0);
      fifo_empty[c] = (fcnt_q[c] == 2'd0);
      cand_v[c]     = !fifo_empty[c] || push_ok[c];
      cand_data[c]  = fifo_empty[c] ? flit_in[c] : mem_q[c][rd_ptr_q[c]];
      ret[c]        = accept && (rx_chan_q == 2'(c + 1));
    end
  end

`ifdef HN_RX_RR_ARB_EN
  logic [1:0] last_q;

  // Round-robin: search REQ->RSP->DAT starting after the last granted channel
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = 1; k <= 3; k++) begin
      int ch;
      ch = (int'(last_q) + k) % 3;
      if (grant == 3'b000 && cand_v[ch]) begin
        grant[ch] = 1'b1;
        grant_idx = 2'(ch);
      end
    end
  end

  // Remember the last channel that won a load of the output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= 2'd2;
    end else if (load && (grant != 3'b000)) begin
      last_q <= grant_idx;
    end
  end
`else
  // Fixed priority RSP > DAT > REQ
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (cand_v[1]) begin
      grant = 3'b010; grant_idx = 2'd1;
    end else if (cand_v[2]) begin
      grant = 3'b100; grant_idx = 2'd2;
    end else if (cand_v[0]) begin
      grant = 3'b001; grant_idx = 2'd0;
    end
  end
`endif

  // Output-stage next state and FIFO write/read strobes
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_chan_d  = rx_chan_q;
    rx_op_d    = rx_op_q;
    rx_src_d   = rx_src_q;
    sel_data   = '0;
    take       = '0;
    fifo_wr    = '0;
    fifo_rd    = '0;
    for (int c = 0; c < 3; c++) begin
      take[c]    = load && grant[c];
      // A flit that bypasses straight into the output stage is not written.
      fifo_wr[c] = push_ok[c] && !(take[c] && fifo_empty[c]);
      fifo_rd[c] = take[c] && !fifo_empty[c];
      if (grant[c]) sel_data = cand_data[c];
    end
    if (load) begin
      rx_valid_d = (grant != 3'b000);
      rx_chan_d  = (grant != 3'b000) ? grant_idx + 2'd1 : 2'd0;
      rx_op_d    = sel_data[6:0];
      rx_src_d   = sel_data[13:7];
    end
  end

  // Credit issue: initial burst of FIFO_DEPTH grants, then one grant per returned entry
  always_comb begin
    lcrdv_d     = '0;
    proto_err_d = proto_err_q || ((flitv & ~push_ok) != 3'b000);
    for (int c = 0; c < 3; c++) begin
      cr_state_d[c] = cr_state_q[c];
      init_cnt_d[c] = init_cnt_q[c];
      pend_d[c]     = pend_q[c] + {1'b0, ret[c]};
      cred_d[c]     = cred_q[c] + {1'b0, lcrdv_q[c]} - {1'b0, push_ok[c]};
      case (cr_state_q[c])
        CR_INIT: begin
          lcrdv_d[c]    = 1'b1;
          init_cnt_d[c] = init_cnt_q[c] + 2'd1;
          if (init_cnt_q[c] == DEPTH_M1) cr_state_d[c] = CR_RUN;
        end
        CR_RUN: begin
          lcrdv_d[c] = (pend_q[c] != 2'd0) || ret[c];
          pend_d[c]  = pend_q[c] + {1'b0, ret[c]} - {1'b0, lcrdv_d[c]};
        end
        default: cr_state_d[c] = CR_INIT;
      endcase
    end
  end

  // Credit and error state registers
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < 3; c++) begin
        cr_state_q[c] <= CR_INIT;
        init_cnt_q[c] <= '0;
        cred_q[c]     <= '0;
        pend_q[c]     <= '0;
      end
      lcrdv_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        cr_state_q[c] <= cr_state_d[c];
        init_cnt_q[c] <= init_cnt_d[c];
        cred_q[c]     <= cred_d[c];
        pend_q[c]     <= pend_d[c];
      end
      lcrdv_q     <= lcrdv_d;
      proto_err_q <= proto_err_d;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < 3; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        fcnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (fifo_wr[c]) wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
        if (fifo_rd[c]) rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
        fcnt_q[c] <= fcnt_q[c] + {1'b0, fifo_wr[c]} - {1'b0, fifo_rd[c]};
      end
    end
  end

  // FIFO storage writes
  // NOTE: the storage array has no reset; pointers and occupancy alone decide which entries are valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (fifo_wr[c]) mem_q[c][wr_ptr_q[c]] <= flit_in[c];
    end
  end

  // Registered presentation to the HN controller
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_valid_q <= 1'b0;
      rx_chan_q  <= '0;
      rx_op_q    <= '0;
      rx_src_q   <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_chan_q  <= rx_chan_d;
      rx_op_q    <= rx_op_d;
      rx_src_q   <= rx_src_d;
    end
  end

  assign RX_REQLCRDV = lcrdv_q[0];
  assign RX_RSPLCRDV = lcrdv_q[1];
  assign RX_DATLCRDV = lcrdv_q[2];
  assign rx_valid    = rx_valid_q;
  assign rx_chan     = rx_chan_q;
  assign rx_opcode   = rx_op_q;
  assign rx_srcID    = rx_src_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_hn_rx_link.sv
// tb_hn_rx_link: directed and random stimulus for hn_rx_link, checked against
// a transaction-level model (per-channel queues, credit counts, pending returns).
module tb_hn_rx_link;

  localparam int DEPTH = 2;

  logic         clk;
  logic         rstn;
  logic [127:0] flit_drv [3];
  logic [2:0]   v_drv;
  logic [2:0]   pend_drv;
  logic         req_lcrdv, rsp_lcrdv, dat_lcrdv;
  logic [6:0]   rx_opcode, rx_srcID;
  logic [1:0]   rx_chan;
  logic         rx_valid, rx_ready, proto_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [13:0] m_q [3][$];
  int          m_cred [3];
  int          m_pend [3];
  int          m_init [3];
  bit   [2:0]  m_lcr;
  bit          m_valid, m_err;
  bit   [1:0]  m_ch;
  bit   [6:0]  m_op, m_src;
`ifdef HN_RX_RR_ARB_EN
  int          m_last;
`endif

  hn_rx_link #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .RX_REQFLIT_128 (flit_drv[0]),
    .RX_RSPFLIT_128 (flit_drv[1]),
    .RX_DATFLIT_128 (flit_drv[2]),
    .RX_REQFLITV    (v_drv[0]),
    .RX_RSPFLITV    (v_drv[1]),
    .RX_DATFLITV    (v_drv[2]),
    .RX_REQFLITPEND (pend_drv[0]),
    .RX_RSPFLITPEND (pend_drv[1]),
    .RX_DATFLITPEND (pend_drv[2]),
    .RX_REQLCRDV    (req_lcrdv),
    .RX_RSPLCRDV    (rsp_lcrdv),
    .RX_DATLCRDV    (dat_lcrdv),
    .rx_opcode      (rx_opcode),
    .rx_srcID       (rx_srcID),
    .rx_chan        (rx_chan),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_q[c].delete();
      m_cred[c] = 0;
      m_pend[c] = 0;
      m_init[c] = DEPTH;
    end
    m_lcr   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_ch    = '0;
    m_op    = '0;
    m_src   = '0;
`ifdef HN_RX_RR_ARB_EN
    m_last  = 2;
`endif
  endtask

  function automatic int pick();
    int r;
    r = -1;
`ifdef HN_RX_RR_ARB_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (r < 0 && m_q[c].size() > 0) r = c;
    end
`else
    if (m_q[1].size() > 0)      r = 1;
    else if (m_q[2].size() > 0) r = 2;
    else if (m_q[0].size() > 0) r = 0;
`endif
    return r;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_step();
    bit          acc, ld;
    bit   [2:0]  ok;
    int          sel;
    logic [13:0] item;
    acc = m_valid && rx_ready;
    ld  = !m_valid || rx_ready;
    for (int c = 0; c < 3; c++) begin
      ok[c] = v_drv[c] && (m_cred[c] > 0);
      if (v_drv[c] && !ok[c]) m_err = 1'b1;
      if (ok[c]) m_q[c].push_back(flit_drv[c][13:0]);
    end
    for (int c = 0; c < 3; c++) begin
      m_cred[c] = m_cred[c] + int'(m_lcr[c]) - int'(ok[c]);
      if (acc && int'(m_ch) == c + 1) m_pend[c]++;
      if (m_init[c] > 0) begin
        m_lcr[c] = 1'b1;
        m_init[c]--;
      end else if (m_pend[c] > 0) begin
        m_lcr[c] = 1'b1;
        m_pend[c]--;
      end else begin
        m_lcr[c] = 1'b0;
      end
    end
    if (ld) begin
      sel = pick();
      if (sel < 0) begin
        m_valid = 1'b0; m_ch = '0; m_op = '0; m_src = '0;
      end else begin
        item    = m_q[sel].pop_front();
        m_valid = 1'b1;
        m_ch    = 2'(sel + 1);
        m_op    = item[6:0];
        m_src   = item[13:7];
`ifdef HN_RX_RR_ARB_EN
        m_last  = sel;
`endif
      end
    end
  endtask

  task automatic compare_all();
    check("rx_valid",  rx_valid,  m_valid);
    check("rx_opcode", rx_opcode, m_op);
    check("rx_srcID",  rx_srcID,  m_src);
    check("rx_chan",   rx_chan,   m_ch);
    check("lcrdv",     {dat_lcrdv, rsp_lcrdv, req_lcrdv}, m_lcr);
    check("proto_err", proto_err, m_err);
  endtask

  // One clock: predict, take the edge, sample 1 ns later and compare
  task automatic tick();
    pend_drv = 3'($urandom);
    if (!rstn) model_reset();
    else       model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive_flit(input int c, input logic [6:0] op, input logic [6:0] src);
    logic [127:0] f;
    f = {$urandom, $urandom, $urandom, $urandom};
    f[13:0] = {src, op};
    flit_drv[c] = f;
    v_drv[c] = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rx_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 3; c++) begin
        flit_drv[c] = {$urandom, $urandom, $urandom, $urandom};
        v_drv[c] = (m_cred[c] > 0) && ($urandom_range(0, 1) == 1);
      end
      tick();
    end
    v_drv = '0;
  endtask

  task automatic idle(input int n);
    v_drv = '0;
    rx_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rstn     = 1'b0;
    v_drv    = '0;
    pend_drv = '0;
    rx_ready = 1'b0;
    for (int c = 0; c < 3; c++) flit_drv[c] = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    compare_all();

    // Initial credit burst: high on cycles 1 and 2 after release, low on 3
    rstn = 1'b1;
    tick();
    check("init_c1_lcrdv", {dat_lcrdv, rsp_lcrdv, req_lcrdv}, 3'b111);
    tick();
    check("init_c2_lcrdv", {dat_lcrdv, rsp_lcrdv, req_lcrdv}, 3'b111);
    tick();
    check("init_c3_lcrdv", {dat_lcrdv, rsp_lcrdv, req_lcrdv}, 3'b000);

    // Single REQ flit, presented next cycle, credit returned after acceptance
    rx_ready = 1'b1;
    drive_flit(0, 7'b0000001, 7'b0000001);
    tick();
    check("req_valid",  rx_valid,  1'b1);
    check("req_opcode", rx_opcode, 7'b0000001);
    check("req_srcid",  rx_srcID,  7'b0000001);
    check("req_chan",   rx_chan,   2'b01);
    v_drv = '0;
    tick();
    check("req_return", req_lcrdv, 1'b1);
    idle(3);

    // RSP and REQ on the same cycle: RSP first, then REQ
    drive_flit(1, 7'b0000011, 7'd5);
    drive_flit(0, 7'b0000001, 7'd6);
    tick();
    check("tie_first_chan", rx_chan,   2'b10);
    check("tie_first_op",   rx_opcode, 7'b0000011);
    v_drv = '0;
    tick();
    check("tie_second_chan", rx_chan,   2'b01);
    check("tie_second_op",   rx_opcode, 7'b0000001);
    idle(4);

    // Three RSP flits with no acceptance: third has no credit and is dropped
    rx_ready = 1'b0;
    drive_flit(1, 7'd5, 7'd1);
    tick();
    drive_flit(1, 7'd6, 7'd2);
    tick();
    drive_flit(1, 7'd7, 7'd3);
    tick();
    v_drv = '0;
    tick();
    check("ovf_proto_err", proto_err, 1'b1);
    check("ovf_held_op",   rx_opcode, 7'd5);
    rx_ready = 1'b1;
    tick();
    check("ovf_second_op", rx_opcode, 7'd6);
    idle(5);

    // DAT flit held for five cycles while not accepted
    rx_ready = 1'b0;
    drive_flit(2, 7'b0001010, 7'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      v_drv = '0;
      check("hold_valid",  rx_valid,  1'b1);
      check("hold_opcode", rx_opcode, 7'b0001010);
      check("hold_chan",   rx_chan,   2'b11);
      check("hold_dat_lcrdv", dat_lcrdv, 1'b0);
    end
    rx_ready = 1'b1;
    tick();
    idle(4);

    // Random traffic against the model
    random_cycles(400);
    idle(10);

    // Reset with two REQ flits buffered
    rx_ready = 1'b0;
    drive_flit(0, 7'd9, 7'd4);
    tick();
    drive_flit(0, 7'd10, 7'd4);
    tick();
    v_drv = '0;
    tick();
    check("pre_rst_valid", rx_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_valid", rx_valid,  1'b0);
    check("async_rst_chan",  rx_chan,   2'b00);
    check("async_rst_op",    rx_opcode, 7'd0);
    check("async_rst_err",   proto_err, 1'b0);
    model_reset();
    tick();
    rstn = 1'b1;
    tick();
    check("rst2_c1_lcrdv", {dat_lcrdv, rsp_lcrdv, req_lcrdv}, 3'b111);
    tick();
    check("rst2_c2_lcrdv", {dat_lcrdv, rsp_lcrdv, req_lcrdv}, 3'b111);
    tick();
    check("rst2_c3_lcrdv", {dat_lcrdv, rsp_lcrdv, req_lcrdv}, 3'b000);
    check("rst2_valid",    rx_valid, 1'b0);

    // More random traffic with proto_err cleared
    random_cycles(300);
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
